// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
//
// Purpose:
//   Multi-channel programmable tick generator. Each of NUM_CH channels counts
//   system clocks and produces either a one-cycle strobe every N+1 cycles
//   (pulse mode) or a 50 % square wave with period 2(N+1) (square mode).
//   New divisor/mode values are loaded through a per-channel shadow register.
//   They are committed only at a period boundary, or immediately on the next
//   cycle if the channel is disabled, so a running output never glitches.
//
// Optional feature macro:
//   CLK_DIV_MULTI_SYNC_EN - adds sync_i, a strobe that restarts every channel
//                           in phase and commits any pending shadow values.
//
// Parameters:
//   NUM_CH   number of channels (>= 1)
//   CNT_W    counter / divisor width
//   DEF_DIV  divisor loaded into every channel at reset
//   DEF_MODE mode loaded into every channel at reset (0 pulse, 1 square)
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   ch_en     in   [NUM_CH]  per-channel run enable
//   ld_valid  in   load request
//   ld_ready  out  load accepted this cycle (combinational on ld_ch)
//   ld_ch     in   [CH_W]    target channel of the load
//   ld_div    in   [CNT_W]   new divisor N (period = N+1 cycles)
//   ld_mode   in   new mode
//   out_o     out  [NUM_CH]  registered per-channel outputs
//   sync_i    in   phase-align strobe (CLK_DIV_MULTI_SYNC_EN only)
// ---------------------------------------------------------------------------
module clk_div_multi #(
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = 16,
  parameter  int DEF_DIV  = 2499,
  parameter  int DEF_MODE = 0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [CH_W-1:0]   ld_ch,
  input  logic [CNT_W-1:0]  ld_div,
  input  logic              ld_mode,
  output logic [NUM_CH-1:0] out_o
`ifdef CLK_DIV_MULTI_SYNC_EN
  ,
  input  logic              sync_i
`endif
);

  // Per-channel state
  logic [CNT_W-1:0]  r_cnt     [NUM_CH];
  logic [CNT_W-1:0]  r_div_act [NUM_CH];
  logic [CNT_W-1:0]  r_div_sh  [NUM_CH];
  logic [NUM_CH-1:0] r_mode_act;
  logic [NUM_CH-1:0] r_mode_sh;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_out;

  // Decoded control
  logic              w_sync;
  logic [NUM_CH-1:0] w_sel;       // ld_ch addresses this channel
  logic [NUM_CH-1:0] w_take;      // load transfer into this channel
  logic [NUM_CH-1:0] w_bnd;       // period boundary this cycle
  logic [NUM_CH-1:0] w_hold;      // channel held in restart (disabled/sync)
  logic [NUM_CH-1:0] w_apply;     // commit shadow -> active this cycle
  logic [NUM_CH-1:0] w_mode_nxt;  // mode governing the period that starts

`ifdef CLK_DIV_MULTI_SYNC_EN
  assign w_sync = sync_i;
`else
  assign w_sync = 1'b0;
`endif

  // An out-of-range ld_ch selects no channel, so it sees ld_ready=1 and the
  // transfer lands nowhere.
  assign ld_ready = ~|(w_sel & r_pend);
  assign out_o    = r_out;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here a default ahead of the loop), otherwise a latch is inferred.
  always_comb begin
    w_sel      = '0;
    w_take     = '0;
    w_bnd      = '0;
    w_hold     = '0;
    w_apply    = '0;
    w_mode_nxt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c]      = (ld_ch == CH_W'(c));
      w_take[c]     = ld_valid && ld_ready && w_sel[c];
      w_hold[c]     = w_sync || !ch_en[c];
      w_bnd[c]      = !w_hold[c] && (r_cnt[c] == r_div_act[c]);
      // Uses the registered pend only: a load accepted in this same cycle
      // waits for the following boundary.
      w_apply[c]    = r_pend[c] && (w_hold[c] || w_bnd[c]);
      w_mode_nxt[c] = r_pend[c] ? r_mode_sh[c] : r_mode_act[c];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these arrays are a handful of flops per channel, not a RAM, so
      // resetting them is cheap and keeps the shadow registers defined.
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]     <= '0;
        r_div_act[c] <= CNT_W'(DEF_DIV);
        r_div_sh[c]  <= CNT_W'(DEF_DIV);
      end
      r_mode_act <= {NUM_CH{DEF_MODE != 0}};
      r_mode_sh  <= {NUM_CH{DEF_MODE != 0}};
      r_pend     <= '0;
      r_out      <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // Shadow commit. A transfer is only possible when pend is clear, so
        // commit and capture never target the same channel in one cycle.
        if (w_apply[c]) begin
          r_div_act[c]  <= r_div_sh[c];
          r_mode_act[c] <= r_mode_sh[c];
          r_pend[c]     <= 1'b0;
        end
        if (w_take[c]) begin
          r_div_sh[c]  <= ld_div;
          r_mode_sh[c] <= ld_mode;
          r_pend[c]    <= 1'b1;
        end

        // Counter and output
        if (w_hold[c]) begin
          r_cnt[c] <= '0;
          r_out[c] <= 1'b0;
        end else if (w_bnd[c]) begin
          r_cnt[c] <= '0;
          // The mode of the period being entered decides the boundary
          // output, so a square->pulse switch emits its pulse right here.
          r_out[c] <= w_mode_nxt[c] ? ~r_out[c] : 1'b1;
        end else begin
          r_cnt[c] <= r_cnt[c] + CNT_W'(1);
          if (!r_mode_act[c]) r_out[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_div_multi
//
// Scoreboard bench for clk_div_multi. The stimulus side advances a timestamp
// based reference model (boundary = period position reached via modular
// arithmetic on an absolute cycle index) and pushes the expected out_o and
// ld_ready for every cycle; a monitor pops and compares on the falling edge.
// Three channels are used so that ld_ch can address a nonexistent channel.
// ---------------------------------------------------------------------------
module tb_clk_div_multi;

  localparam int NUM_CH   = 3;
  localparam int CNT_W    = 16;
  localparam int DEF_DIV  = 2499;
  localparam int DEF_MODE = 0;
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic              ld_valid;
  logic              ld_ready;
  logic [CH_W-1:0]   ld_ch;
  logic [CNT_W-1:0]  ld_div;
  logic              ld_mode;
  logic [NUM_CH-1:0] out_o;
  logic              sync_v;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV),
    .DEF_MODE(DEF_MODE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ch_en   (ch_en),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_ch   (ld_ch),
    .ld_div  (ld_div),
    .ld_mode (ld_mode),
    .out_o   (out_o)
`ifdef CLK_DIV_MULTI_SYNC_EN
    ,
    .sync_i  (sync_v)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [NUM_CH-1:0] out;
    logic              rdy;
  } exp_t;

  exp_t   exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  longint m_t;                // index of the next clock edge
  longint m_start [NUM_CH];   // edge at which the current period train began
  int     m_per   [NUM_CH];   // period length in cycles
  bit     m_mode  [NUM_CH];
  bit     m_out   [NUM_CH];
  bit     m_pend  [NUM_CH];
  int     m_shd   [NUM_CH];
  bit     m_shm   [NUM_CH];

  function automatic bit mdl_ready(input int ch);
    if (ch >= NUM_CH) return 1'b1;
    return !m_pend[ch];
  endfunction

  // Advance the model across one clock edge using the inputs sampled there.
  task automatic mdl_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit take;
      bit kill;
      bit bnd;
      if (rst) begin
        m_per[c]   = DEF_DIV + 1;
        m_mode[c]  = (DEF_MODE != 0);
        m_out[c]   = 1'b0;
        m_pend[c]  = 1'b0;
        m_start[c] = m_t + 1;
        continue;
      end
      take = ld_valid && (int'(ld_ch) == c) && !m_pend[c];
      kill = !ch_en[c] || sync_v;
      bnd  = !kill && (((m_t - m_start[c]) % m_per[c]) == longint'(m_per[c] - 1));
      if (kill) begin
        m_out[c]   = 1'b0;
        m_start[c] = m_t + 1;
      end else if (bnd) begin
        bit nm;
        nm = m_pend[c] ? m_shm[c] : m_mode[c];
        m_out[c] = nm ? !m_out[c] : 1'b1;
      end else if (!m_mode[c]) begin
        m_out[c] = 1'b0;
      end
      if (m_pend[c] && (kill || bnd)) begin
        m_per[c]   = m_shd[c] + 1;
        m_mode[c]  = m_shm[c];
        m_pend[c]  = 1'b0;
        m_start[c] = m_t + 1;
      end
      if (take) begin
        m_pend[c] = 1'b1;
        m_shd[c]  = int'(ld_div);
        m_shm[c]  = ld_mode;
      end
    end
    m_t++;
  endtask

  // Push the expectation for the current inputs, then cross one edge.
  task automatic cycle();
    exp_t e;
    for (int c = 0; c < NUM_CH; c++) e.out[c] = m_out[c];
    e.rdy = mdl_ready(int'(ld_ch));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    mdl_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Hold a load request until the model says it is taken (bounded).
  task automatic load(input int ch, input int div, input bit mode);
    bit ok;
    ok       = 1'b0;
    ld_valid = 1'b1;
    ld_ch    = CH_W'(ch);
    ld_div   = CNT_W'(div);
    ld_mode  = mode;
    for (int i = 0; i < 6000; i++) begin
      bit r;
      r = mdl_ready(ch);
      cycle();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL load_timeout ch=%0d: not accepted within 6000 cycles, required acceptance", ch);
    end
    ld_valid = 1'b0;
  endtask

  // ---------------- monitor ----------------
  int mon_cyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_tests++;
        if (out_o !== e.out) begin
          n_fail++;
          $display("FAIL out_o cyc=%0d got=%b exp=%b", mon_cyc, out_o, e.out);
        end
        n_tests++;
        if (ld_ready !== e.rdy) begin
          n_fail++;
          $display("FAIL ld_ready cyc=%0d ld_ch=%0d got=%b exp=%b", mon_cyc, ld_ch, ld_ready, e.rdy);
        end
        mon_cyc++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    ch_en    = 3'b001;
    ld_valid = 1'b0;
    ld_ch    = '0;
    ld_div   = '0;
    ld_mode  = 1'b0;
    sync_v   = 1'b0;
    m_t      = 0;
    @(posedge clk);
    #1;
    mdl_step();
    run(2);
    rst = 1'b0;

    // Default divider on ch0: pulse train with period 2500.
    run(5010);

    // ch1: square N=3 loaded while disabled, then enabled.
    load(1, 3, 1'b1);
    run(2);
    ch_en[1] = 1'b1;
    run(30);

    // ch0 retuned while running; second ch0 load stalls, ch2 load goes in.
    load(0, 9, 1'b0);
    load(2, 4, 1'b0);
    load(0, 6, 1'b0);
    ld_ch = '0;
    run(40);

    // ch2: N=0 pulse -> continuously high; load to nonexistent channel 3.
    load(2, 0, 1'b0);
    ch_en[2] = 1'b1;
    run(8);
    load(3, 7, 1'b1);
    run(8);

    // ch2: N=5, drop enable mid-period, re-enable 7 cycles later.
    load(2, 5, 1'b0);
    run(9);
    ch_en[2] = 1'b0;
    run(7);
    ch_en[2] = 1'b1;
    run(15);

    // Square -> pulse switch at a boundary on ch1.
    load(1, 2, 1'b0);
    run(20);

`ifdef CLK_DIV_MULTI_SYNC_EN
    // Two channels at N=4 and N=9 thrown out of phase, then aligned.
    ch_en = 3'b011;
    load(0, 4, 1'b0);
    load(1, 9, 1'b0);
    run(13);
    sync_v = 1'b1;
    cycle();
    sync_v = 1'b0;
    run(35);
`endif

    // Randomised phase.
    for (int i = 0; i < 2500; i++) begin
      ld_valid = ($urandom_range(7) == 0);
      ld_ch    = CH_W'($urandom_range(3));
      ld_div   = CNT_W'($urandom_range(12));
      ld_mode  = 1'($urandom_range(1));
      if ($urandom_range(39) == 0) ch_en[$urandom_range(NUM_CH-1)] ^= 1'b1;
`ifdef CLK_DIV_MULTI_SYNC_EN
      sync_v   = ($urandom_range(59) == 0);
`endif
      cycle();
    end
    ld_valid = 1'b0;
    sync_v   = 1'b0;

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
